// File: rtl/mod_write_buffer_if.sv
// Bundles the cache-side store/read-miss signals and the SRAM controller data port of mod_write_buffer.
// slave  : the write buffer itself. It takes stores, read misses and SRAM responses, and drives the SRAM requests.
// master : the environment, meaning the cache controller together with the SRAM controller.
interface mod_write_buffer_if;
    // cache controller side
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_done;
    logic        empty;
    // SRAM controller data port
    logic        sram_de;
    logic [1:0]  sram_drw;
    logic [31:0] sram_daddr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;
    logic        sram_nrdy;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, sram_dout, sram_nrdy,
        output wr_ready, rd_data, rd_done, empty, sram_de, sram_drw, sram_daddr, sram_din
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr, sram_dout, sram_nrdy,
        input  wr_ready, rd_data, rd_done, empty, sram_de, sram_drw, sram_daddr, sram_din
    );
endinterface

// File: rtl/mod_write_buffer.sv
// Posted-write FIFO plus read arbiter in front of the SRAM controller data port. Read misses bypass queued
// stores unless they hit a pending entry. A write holds the port for >= 2 cycles; a clean read from IDLE
// completes 2 cycles after the request when SRAM answers at once. wr_ready drops only when all entries are full.
//
// Ports: clk, rst (synchronous, active-high); bus (mod_write_buffer_if.slave):
//   wr_valid/wr_addr/wr_data/wr_ready : store push, taken when wr_valid & wr_ready
//   rd_req/rd_addr/rd_data/rd_done     : read miss; rd_req is held until the one-cycle rd_done pulse
//   empty                              : no pending stores
//   sram_de/drw/daddr/din, sram_dout/nrdy : single-request SRAM controller data interface
// Build option: define WB_FORWARD_EN to service conflicting reads from the youngest matching entry (FWD state).
module mod_write_buffer #(
    parameter int DEPTH_LOG2 = 2
) (
    input logic               clk,
    input logic               rst,
    mod_write_buffer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_ISSUE  = 3'd1,
        W_RETIRE = 3'd2,
        R_ISSUE  = 3'd3,
        R_RETIRE = 3'd4
`ifdef WB_FORWARD_EN
        ,FWD     = 3'd5
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_addr [DEPTH];
    logic [31:0] r_data [DEPTH];
    ptr_t        r_wptr;
    ptr_t        r_rptr;
    cnt_t        r_count;

    logic [31:0] r_sram_daddr;
    logic [31:0] r_sram_din;
    logic [31:0] r_rd_data;

    logic        w_wr_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_match;
    logic        w_conflict;
    logic        w_sram_de;
    logic [1:0]  w_sram_drw;
    logic        w_rd_done;
`ifdef WB_FORWARD_EN
    logic [31:0] w_fwd_data;
`endif

    // Depends on registered count only, so there is no input-to-wr_ready path. A pop cycle therefore
    // still reports full, and the freed slot shows up one cycle later.
    assign w_wr_ready = (r_count != cnt_t'(DEPTH));
    assign w_push     = bus.wr_valid & w_wr_ready;
    assign w_pop      = (r_state == W_RETIRE);

    // Scan the live entries from oldest to youngest, so the last hit is the youngest store to that word.
    always_comb begin
        w_match = 1'b0;
`ifdef WB_FORWARD_EN
        w_fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if ((cnt_t'(k) < r_count) &&
                (r_addr[ptr_t'(r_rptr + ptr_t'(k))][31:2] == bus.rd_addr[31:2])) begin
                w_match = 1'b1;
`ifdef WB_FORWARD_EN
                w_fwd_data = r_data[ptr_t'(r_rptr + ptr_t'(k))];
`endif
            end
        end
    end

    assign w_conflict = bus.rd_req & w_match;

    always_comb begin
        w_next_state = r_state;
        w_sram_de    = 1'b0;
        w_sram_drw   = 2'b00;
        w_rd_done    = 1'b0;
        case (r_state)
            IDLE: begin
                // A clean read jumps ahead of queued stores. A conflicting read either forwards or
                // lets the queue drain, one entry per pass through IDLE, until no match remains.
                if (bus.rd_req && !w_conflict) begin
                    w_next_state = R_ISSUE;
                end
`ifdef WB_FORWARD_EN
                else if (w_conflict) begin
                    w_next_state = FWD;
                end
`endif
                else if (r_count != '0) begin
                    w_next_state = W_ISSUE;
                end
            end
            W_ISSUE: begin
                w_sram_de  = 1'b1;
                w_sram_drw = 2'b01;
                if (!bus.sram_nrdy) begin
                    w_next_state = W_RETIRE;
                end
            end
            W_RETIRE: begin
                // de low here gives the SRAM controller its rearm cycle.
                w_next_state = IDLE;
            end
            R_ISSUE: begin
                w_sram_de  = 1'b1;
                w_sram_drw = 2'b10;
                if (!bus.sram_nrdy) begin
                    w_next_state = R_RETIRE;
                end
            end
            R_RETIRE: begin
                w_rd_done    = 1'b1;
                w_next_state = IDLE;
            end
`ifdef WB_FORWARD_EN
            FWD: begin
                w_rd_done    = 1'b1;
                w_next_state = IDLE;
            end
`endif
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_sram_daddr <= '0;
            r_sram_din   <= '0;
            r_rd_data    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_push) begin
                r_wptr <= r_wptr + ptr_t'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ptr_t'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
            // The request fields are latched on entry, so they stay stable for however long SRAM stalls.
            if (r_state == IDLE && w_next_state == W_ISSUE) begin
                r_sram_daddr <= r_addr[r_rptr];
                r_sram_din   <= r_data[r_rptr];
            end
            if (r_state == IDLE && w_next_state == R_ISSUE) begin
                r_sram_daddr <= bus.rd_addr;
            end
            if (r_state == R_ISSUE && !bus.sram_nrdy) begin
                r_rd_data <= bus.sram_dout;
            end
`ifdef WB_FORWARD_EN
            if (r_state == IDLE && w_next_state == FWD) begin
                r_rd_data <= w_fwd_data;
            end
`endif
        end
    end

    // Entry storage needs no reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_addr[r_wptr] <= bus.wr_addr;
            r_data[r_wptr] <= bus.wr_data;
        end
    end

    assign bus.wr_ready   = w_wr_ready;
    assign bus.empty      = (r_count == '0);
    assign bus.rd_done    = w_rd_done;
    assign bus.rd_data    = r_rd_data;
    assign bus.sram_de    = w_sram_de;
    assign bus.sram_drw   = w_sram_drw;
    assign bus.sram_daddr = r_sram_daddr;
    assign bus.sram_din   = r_sram_din;
endmodule

// File: tb/tb_mod_write_buffer.sv
`timescale 1ns/1ps
module tb_mod_write_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_write_buffer_if bus();
    mod_write_buffer #(.DEPTH_LOG2(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]  drw;
        logic [31:0] addr;
        logic [31:0] data;
        int          cs;
        int          ce;
    } ev_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int proto_err = 0;
    int ord_err = 0;
    int sram_lat = 0;
    int sram_budget = -1;   // completions the SRAM model still grants; -1 means unlimited
    int wait_cnt = 0;
    bit prev_de = 1'b0;
    ev_t cur;
    ev_t evlog[$];
    logic [63:0] exp_wq[$];             // stores accepted but not yet written, oldest first
    logic [31:0] ref_mem [logic [29:0]]; // architectural memory as the CPU sees it
    logic [31:0] sram_mem [logic [29:0]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : dflt(a);
    endfunction

    // SRAM controller model. It acts 1ns after the falling edge, so the tasks' changes at that edge are
    // already visible.
    always begin
        @(negedge clk);
        #1;
        if (rst === 1'b1) begin
            bus.sram_nrdy = 1'b1;
            wait_cnt = 0;
            prev_de = 1'b0;
        end else begin
            if (bus.sram_de === 1'b1) begin
                if (wait_cnt == 0) begin
                    if (prev_de) proto_err++;
                    cur = '{drw: bus.sram_drw, addr: bus.sram_daddr, data: bus.sram_din, cs: cyc, ce: 0};
                end else if (bus.sram_drw !== cur.drw || bus.sram_daddr !== cur.addr ||
                             (cur.drw == 2'b01 && bus.sram_din !== cur.data)) begin
                    proto_err++;
                end
                if (bus.sram_drw !== 2'b01 && bus.sram_drw !== 2'b10) proto_err++;
                if (wait_cnt >= sram_lat && sram_budget != 0) begin
                    bus.sram_nrdy = 1'b0;
                    cur.ce = cyc;
                    if (cur.drw == 2'b01) begin
                        sram_mem[cur.addr[31:2]] = cur.data;
                        if (exp_wq.size() == 0) ord_err++;
                        else begin
                            if (exp_wq[0] !== {cur.addr, cur.data}) ord_err++;
                            void'(exp_wq.pop_front());
                        end
                    end else begin
                        bus.sram_dout = sram_mem.exists(cur.addr[31:2]) ? sram_mem[cur.addr[31:2]] : dflt(cur.addr);
                        cur.data = bus.sram_dout;
                    end
                    evlog.push_back(cur);
                    if (sram_budget > 0) sram_budget--;
                    wait_cnt = 0;
                end else begin
                    bus.sram_nrdy = 1'b1;
                    wait_cnt++;
                end
            end else begin
                bus.sram_nrdy = 1'b1;
                wait_cnt = 0;
            end
            prev_de = (bus.sram_de === 1'b1);
        end
    end

    task automatic push_word(input logic [31:0] a, input logic [31:0] d, output bit ok);
        int w;
        w = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        while (bus.wr_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        ok = (w < 400);
        if (ok) begin
            ref_mem[a[31:2]] = d;
            exp_wq.push_back({a, d});
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat, output bit ok);
        int w;
        w = 0;
        bus.rd_req = 1'b1;
        bus.rd_addr = a;
        do begin
            @(negedge clk);
            w++;
        end while (bus.rd_done !== 1'b1 && w < 400);
        ok = (bus.rd_done === 1'b1);
        d = bus.rd_data;
        lat = w;
        bus.rd_req = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int w;
        w = 0;
        while (!(bus.empty === 1'b1 && bus.sram_de === 1'b0 && exp_wq.size() == 0) && w < 600) begin
            @(negedge clk);
            w++;
        end
        ok = (w < 600);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); end
        n_chk++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_chk++; if (bus.rd_done !== 1'b0) begin n_fail++; $display("FAIL reset_rd_done got %b want 0", bus.rd_done); end
        n_chk++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
        n_chk++; if (bus.sram_de !== 1'b0) begin n_fail++; $display("FAIL reset_sram_de got %b want 0", bus.sram_de); end
        n_chk++; if (bus.sram_drw !== 2'b00) begin n_fail++; $display("FAIL reset_sram_drw got %b want 00", bus.sram_drw); end
        n_chk++; if (bus.sram_daddr !== 32'h0) begin n_fail++; $display("FAIL reset_sram_daddr got %h want 0", bus.sram_daddr); end
        n_chk++; if (bus.sram_din !== 32'h0) begin n_fail++; $display("FAIL reset_sram_din got %h want 0", bus.sram_din); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill_drain();
        bit ok;
        int base;
        sram_lat = 0;
        sram_budget = 0;
        base = evlog.size();
        for (int i = 0; i < 4; i++) begin
            push_word(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), ok);
            n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fill_push%0d accepted=%b want 1", i, ok); end
        end
        n_chk++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_wr_ready got %b want 0", bus.wr_ready); end
        n_chk++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty got %b want 0", bus.empty); end
        sram_budget = -1;
        wait_idle(ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fill_drain_timeout got %b want 1", ok); end
        n_chk++; if (evlog.size() - base !== 4) begin n_fail++; $display("FAIL fill_nwrites got %0d want 4", evlog.size() - base); end
        if (evlog.size() - base == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (evlog[base+i].drw !== 2'b01 || evlog[base+i].addr !== 32'h100 + 32'(4 * i) ||
                    evlog[base+i].data !== 32'hA0 + 32'(i)) begin
                    n_fail++;
                    $display("FAIL fill_write%0d got drw=%b addr=%h data=%h want 01/%h/%h", i, evlog[base+i].drw,
                             evlog[base+i].addr, evlog[base+i].data, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
                end
                if (i > 0) begin
                    n_chk++; if (evlog[base+i].ce - evlog[base+i].cs !== 0) begin n_fail++; $display("FAIL fill_de_len%0d got %0d extra cycles want 0", i, evlog[base+i].ce - evlog[base+i].cs); end
                    n_chk++; if (evlog[base+i].cs - evlog[base+i-1].ce < 2) begin n_fail++; $display("FAIL fill_gap%0d got %0d want >=2", i, evlog[base+i].cs - evlog[base+i-1].ce); end
                end
            end
        end
        n_chk++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fill_end_empty got %b want 1", bus.empty); end
        n_chk++; if (ord_err !== 0) begin n_fail++; $display("FAIL fill_order got %0d errors want 0", ord_err); end
    endtask

    task automatic test_read_priority();
        bit ok;
        int base;
        int w;
        logic [31:0] d;
        sram_lat = 3;
        sram_budget = -1;
        base = evlog.size();
        d = $urandom();
        bus.wr_valid = 1'b1; bus.wr_addr = 32'h200; bus.wr_data = d;
        ref_mem[30'h80] = d;
        exp_wq.push_back({32'h200, d});
        bus.rd_req = 1'b1; bus.rd_addr = 32'h300;
        w = 0;
        do begin
            @(negedge clk);
            w++;
            bus.wr_valid = 1'b0;
        end while (bus.rd_done !== 1'b1 && w < 400);
        n_chk++; if (bus.rd_done !== 1'b1) begin n_fail++; $display("FAIL prio_rd_done got %b want 1", bus.rd_done); end
        n_chk++; if (w !== 5) begin n_fail++; $display("FAIL prio_latency got %0d want 5", w); end
        n_chk++; if (bus.rd_data !== exp_rd(32'h300)) begin n_fail++; $display("FAIL prio_rd_data got %h want %h", bus.rd_data, exp_rd(32'h300)); end
        bus.rd_req = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.rd_done !== 1'b0) begin n_fail++; $display("FAIL prio_pulse got %b want 0", bus.rd_done); end
        wait_idle(ok);
        n_chk++; if (ok !== 1'b1 || evlog.size() - base !== 2) begin n_fail++; $display("FAIL prio_events got %0d want 2", evlog.size() - base); end
        else begin
            n_chk++; if (evlog[base].drw !== 2'b10 || evlog[base].addr !== 32'h300) begin n_fail++; $display("FAIL prio_first got drw=%b addr=%h want 10/00000300", evlog[base].drw, evlog[base].addr); end
            n_chk++; if (evlog[base+1].drw !== 2'b01 || evlog[base+1].addr !== 32'h200) begin n_fail++; $display("FAIL prio_second got drw=%b addr=%h want 01/00000200", evlog[base+1].drw, evlog[base+1].addr); end
        end
    endtask

    task automatic test_conflict();
        bit ok;
        int base;
        int w;
        int nrd;
        int ev_at_done;
        sram_lat = 0;
        sram_budget = -1;
        base = evlog.size();
        bus.wr_valid = 1'b1; bus.wr_addr = 32'h400; bus.wr_data = 32'h11;
        ref_mem[32'h400 >> 2] = 32'h11; exp_wq.push_back({32'h400, 32'h11});
        @(negedge clk);
        bus.wr_addr = 32'h404; bus.wr_data = 32'h22;
        ref_mem[32'h404 >> 2] = 32'h22; exp_wq.push_back({32'h404, 32'h22});
        bus.rd_req = 1'b1; bus.rd_addr = 32'h400;
        w = 0;
        do begin
            @(negedge clk);
            w++;
            bus.wr_valid = 1'b0;
        end while (bus.rd_done !== 1'b1 && w < 400);
        ev_at_done = evlog.size() - base;
        n_chk++; if (bus.rd_done !== 1'b1) begin n_fail++; $display("FAIL confl_rd_done got %b want 1", bus.rd_done); end
        n_chk++; if (bus.rd_data !== 32'h11) begin n_fail++; $display("FAIL confl_rd_data got %h want 00000011", bus.rd_data); end
        bus.rd_req = 1'b0;
        wait_idle(ok);
        nrd = 0;
        for (int i = base; i < evlog.size(); i++) if (evlog[i].drw == 2'b10) nrd++;
`ifdef WB_FORWARD_EN
        n_chk++; if (w !== 1) begin n_fail++; $display("FAIL confl_fwd_latency got %0d want 1", w); end
        n_chk++; if (nrd !== 0) begin n_fail++; $display("FAIL confl_fwd_sram_reads got %0d want 0", nrd); end
        n_chk++; if (ev_at_done !== 0) begin n_fail++; $display("FAIL confl_fwd_events_before_done got %0d want 0", ev_at_done); end
`else
        n_chk++; if (nrd !== 1) begin n_fail++; $display("FAIL confl_sram_reads got %0d want 1", nrd); end
        n_chk++; if (ev_at_done !== 2) begin n_fail++; $display("FAIL confl_events_before_done got %0d want 2", ev_at_done); end
`endif
        n_chk++; if (ok !== 1'b1 || ord_err !== 0) begin n_fail++; $display("FAIL confl_drain got ok=%b ord_err=%0d want 1/0", ok, ord_err); end
    endtask

    task automatic test_youngest();
        bit ok;
        int base;
        int w;
        int ev_at_done;
        sram_lat = 0;
        sram_budget = 0;
        base = evlog.size();
        push_word(32'h700, 32'h77, ok);
        push_word(32'h500, 32'h1, ok);
        push_word(32'h500, 32'h2, ok);
        bus.rd_req = 1'b1; bus.rd_addr = 32'h500;
        @(negedge clk);
        sram_budget = -1;
        w = 0;
        while (bus.rd_done !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        ev_at_done = evlog.size() - base;
        n_chk++; if (bus.rd_done !== 1'b1) begin n_fail++; $display("FAIL young_rd_done got %b want 1", bus.rd_done); end
        n_chk++; if (bus.rd_data !== exp_rd(32'h500)) begin n_fail++; $display("FAIL young_rd_data got %h want %h", bus.rd_data, exp_rd(32'h500)); end
        bus.rd_req = 1'b0;
        wait_idle(ok);
`ifdef WB_FORWARD_EN
        n_chk++; if (ev_at_done !== 1) begin n_fail++; $display("FAIL young_fwd_events_before_done got %0d want 1", ev_at_done); end
`else
        n_chk++; if (ev_at_done !== 4) begin n_fail++; $display("FAIL young_events_before_done got %0d want 4", ev_at_done); end
`endif
        n_chk++; if (ok !== 1'b1 || ord_err !== 0) begin n_fail++; $display("FAIL young_drain got ok=%b ord_err=%0d want 1/0", ok, ord_err); end
    endtask

    task automatic test_full_pop();
        bit ok;
        int base;
        logic [31:0] d5;
        sram_lat = 0;
        sram_budget = 0;
        base = evlog.size();
        for (int i = 0; i < 4; i++) push_word(32'hC00 + 32'(4 * i), $urandom(), ok);
        n_chk++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready got %b want 0", bus.wr_ready); end
        d5 = $urandom();
        bus.wr_valid = 1'b1; bus.wr_addr = 32'hC10; bus.wr_data = d5;
        sram_budget = 1;
        @(negedge clk);
        n_chk++; if (bus.sram_de !== 1'b0 || bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_cycle got de=%b wr_ready=%b want 0/0", bus.sram_de, bus.wr_ready); end
        @(negedge clk);
        n_chk++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_freed_slot got %b want 1", bus.wr_ready); end
        ref_mem[32'hC10 >> 2] = d5; exp_wq.push_back({32'hC10, d5});
        @(negedge clk);
        n_chk++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_again got %b want 0", bus.wr_ready); end
        bus.wr_valid = 1'b0;
        sram_budget = -1;
        wait_idle(ok);
        n_chk++; if (ok !== 1'b1 || evlog.size() - base !== 5 || ord_err !== 0) begin n_fail++; $display("FAIL full_drain got ok=%b writes=%0d ord_err=%0d want 1/5/0", ok, evlog.size() - base, ord_err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base;
        int w;
        sram_lat = 0;
        sram_budget = 0;
        for (int i = 0; i < 3; i++) push_word(32'hA00 + 32'(4 * i), $urandom(), ok);
        w = 0;
        while (bus.sram_de !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        n_chk++; if (bus.sram_de !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_issue got %b want 1", bus.sram_de); end
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.sram_de !== 1'b0 || bus.sram_drw !== 2'b00) begin n_fail++; $display("FAIL rstmid_de got de=%b drw=%b want 0/00", bus.sram_de, bus.sram_drw); end
        n_chk++; if (bus.empty !== 1'b1 || bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_fifo got empty=%b wr_ready=%b want 1/1", bus.empty, bus.wr_ready); end
        rst = 1'b0;
        exp_wq.delete();
        ref_mem = sram_mem;
        base = evlog.size();
        sram_budget = -1;
        repeat (20) @(negedge clk);
        n_chk++; if (evlog.size() !== base || bus.sram_de !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet got events=%0d de=%b want 0/0", evlog.size() - base, bus.sram_de); end
    endtask

    task automatic test_random();
        bit ok;
        int lat;
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 200; i++) begin
            sram_lat = $urandom_range(0, 3);
            a = 32'h800 + 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 2) != 0) begin
                push_word(a, $urandom(), ok);
                n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_push%0d accepted=%b want 1", i, ok); end
            end else begin
                do_read(a, d, lat, ok);
                n_chk++; if (ok !== 1'b1 || d !== exp_rd(a)) begin n_fail++; $display("FAIL rand_read%0d addr=%h got %h (done=%b) want %h", i, a, d, ok, exp_rd(a)); end
            end
            repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle(ok);
        n_chk++; if (ok !== 1'b1 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL rand_drain got ok=%b empty=%b want 1/1", ok, bus.empty); end
        n_chk++; if (ord_err !== 0) begin n_fail++; $display("FAIL rand_order got %0d want 0", ord_err); end
        n_chk++; if (proto_err !== 0) begin n_fail++; $display("FAIL sram_protocol got %0d violations want 0", proto_err); end
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.sram_nrdy = 1'b1; bus.sram_dout = '0;
        test_reset();
        test_fill_drain();
        test_read_priority();
        test_conflict();
        test_youngest();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
